// File: rtl/calc_pkg.sv
// calc_pkg: shared types for the calculator controller.
//   calc_state_t : 3-bit FSM state encoding (S_OP1..S_SHOW = 0..4)
//   calc_op_t    : 2-bit operator code (ADD, SUB, MUL, DIV)
package calc_pkg;

  typedef enum logic [2:0] {
    S_OP1  = 3'd0,
    S_OP2  = 3'd1,
    S_OPER = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } calc_state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } calc_op_t;

  localparam int CALC_DATA_W_DEF = 4;

endpackage

// File: rtl/calc_if.sv
// calc_if: user-side bus of the calculator controller.
//   master : drives confirm, display_mode_change, operator_select, operand_input
//            and observes state, display_value, display_mode, result_valid, ovf, div_err
//   slave  : the controller's view (directions mirrored)
// RES_W must stay >= 2*DATA_W so MUL results are exact.
interface calc_if #(
  parameter int DATA_W = 4,
  parameter int RES_W  = 2 * DATA_W
) ();
  logic              confirm;
  logic              display_mode_change;
  logic [1:0]        operator_select;
  logic [DATA_W-1:0] operand_input;
  logic [2:0]        state;
  logic [RES_W-1:0]  display_value;
  logic              display_mode;
  logic              result_valid;
  logic              ovf;
  logic              div_err;

  modport master (
    output confirm, display_mode_change, operator_select, operand_input,
    input  state, display_value, display_mode, result_valid, ovf, div_err
  );

  modport slave (
    input  confirm, display_mode_change, operator_select, operand_input,
    output state, display_value, display_mode, result_valid, ovf, div_err
  );
endinterface

// File: rtl/calc_alu.sv
// calc_alu: combinational signed ALU.
//   i_a, i_b        : signed DATA_W operands, sign-extended to RES_W before use
//   i_op            : operator (calc_op_t)
//   o_result        : signed RES_W result (DIV truncates toward zero)
//   o_div_by_zero   : DIV with zero divisor; o_result forced to 0 then
module calc_alu
  import calc_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int RES_W  = 2 * DATA_W
) (
  input  logic [DATA_W-1:0]       i_a,
  input  logic [DATA_W-1:0]       i_b,
  input  calc_op_t                i_op,
  output logic signed [RES_W-1:0] o_result,
  output logic                    o_div_by_zero
);

  logic signed [RES_W-1:0] w_a, w_b;

  assign w_a = {{(RES_W-DATA_W){i_a[DATA_W-1]}}, i_a};
  assign w_b = {{(RES_W-DATA_W){i_b[DATA_W-1]}}, i_b};

  // With RES_W >= 2*DATA_W, every product and the -min/-1 quotient fit exactly.
  always_comb begin
    o_result      = '0;
    o_div_by_zero = 1'b0;
    case (i_op)
      OP_ADD: o_result = w_a + w_b;
      OP_SUB: o_result = w_a - w_b;
      OP_MUL: o_result = w_a * w_b;
      OP_DIV: begin
        if (w_b == '0) o_div_by_zero = 1'b1;
        else           o_result      = w_a / w_b;
      end
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/calc_controller.sv
// calc_controller: operand/operator entry FSM driving a signed ALU and display.
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high; dominates all other inputs
//   bus    : calc_if.slave (confirm/mode pulses, operator, operand in;
//            state, display_value, display_mode, result_valid, ovf, div_err out)
// Optional feature macro CALC_CHAIN_EN: confirm in S_SHOW reloads operand1 from
// the low DATA_W bits of the result and skips straight to S_OP2.
module calc_controller
  import calc_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int RES_W  = 2 * DATA_W
) (
  input logic clk,
  input logic reset,
  calc_if.slave bus
);

  calc_state_t       r_state, w_next_state;
  logic [DATA_W-1:0] r_operand1, r_operand2;
  calc_op_t          r_op;
  logic [RES_W-1:0]  r_result;
  logic              r_display_mode, r_result_valid, r_ovf, r_div_err;

  logic signed [RES_W-1:0] w_result;
  logic                    w_div_by_zero, w_ovf;
  logic [RES_W-1:0]        w_display;

  calc_alu #(.DATA_W(DATA_W), .RES_W(RES_W)) u_alu (
    .i_a          (r_operand1),
    .i_b          (r_operand2),
    .i_op         (r_op),
    .o_result     (w_result),
    .o_div_by_zero(w_div_by_zero)
  );

  // In range iff the bits from the DATA_W sign position upward are all equal.
  assign w_ovf = !((&w_result[RES_W-1:DATA_W-1]) || !(|w_result[RES_W-1:DATA_W-1]));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_OP1;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_OP1:  if (bus.confirm) w_next_state = S_OP2;
      S_OP2:  if (bus.confirm) w_next_state = S_OPER;
      S_OPER: if (bus.confirm) w_next_state = S_EXEC;
      S_EXEC: w_next_state = S_SHOW;
      S_SHOW: begin
`ifdef CALC_CHAIN_EN
        if (bus.confirm) w_next_state = S_OP2;
`else
        if (bus.confirm) w_next_state = S_OP1;
`endif
      end
      default: w_next_state = S_OP1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_operand1     <= '0;
      r_operand2     <= '0;
      r_op           <= OP_ADD;
      r_result       <= '0;
      r_display_mode <= 1'b0;
      r_result_valid <= 1'b0;
      r_ovf          <= 1'b0;
      r_div_err      <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      if (bus.display_mode_change) r_display_mode <= ~r_display_mode;
      if (bus.confirm) begin
        case (r_state)
          S_OP1:  r_operand1 <= bus.operand_input;
          S_OP2:  r_operand2 <= bus.operand_input;
          S_OPER: r_op       <= calc_op_t'(bus.operator_select);
`ifdef CALC_CHAIN_EN
          S_SHOW: r_operand1 <= r_result[DATA_W-1:0];
`endif
          default: ;
        endcase
      end
      // Result and flags only move on the single S_EXEC edge.
      if (r_state == S_EXEC) begin
        r_result       <= w_result;
        r_ovf          <= w_ovf;
        r_div_err      <= w_div_by_zero;
        r_result_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    w_display = '0;
    case (r_state)
      S_OP1, S_OP2:   w_display = {{(RES_W-DATA_W){bus.operand_input[DATA_W-1]}}, bus.operand_input};
      S_OPER, S_EXEC: w_display = {{(RES_W-DATA_W){r_operand2[DATA_W-1]}}, r_operand2};
      S_SHOW:         w_display = r_result;
      default:        w_display = '0;
    endcase
  end

  assign bus.state         = r_state;
  assign bus.display_value = w_display;
  assign bus.display_mode  = r_display_mode;
  assign bus.result_valid  = r_result_valid;
  assign bus.ovf           = r_ovf;
  assign bus.div_err       = r_div_err;

endmodule

// File: tb/tb_calc_controller.sv
// tb_calc_controller: directed self-checking bench for calc_controller (DATA_W=4).
module tb_calc_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  calc_if #(.DATA_W(4), .RES_W(8)) bus ();

  calc_controller #(.DATA_W(4), .RES_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse();
    bus.confirm = 1'b1;
    step();
    bus.confirm = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Enter both operands and the operator; returns just after the edge into S_EXEC.
  task automatic run_ops(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    bus.operand_input = a;   pulse();
    bus.operand_input = b;   pulse();
    bus.operator_select = op; pulse();
  endtask

  task automatic test_reset();
    bus.confirm = 0; bus.display_mode_change = 0;
    bus.operator_select = 0; bus.operand_input = 0;
    reset = 1'b1; step(); step(); reset = 1'b0;
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state); end
    checks++; if ({bus.display_mode, bus.result_valid, bus.ovf, bus.div_err} !== 4'b0)
      begin errors++; $display("FAIL reset_flags got %b want 0000", {bus.display_mode, bus.result_valid, bus.ovf, bus.div_err}); end
    checks++; if (bus.display_value !== 8'h00) begin errors++; $display("FAIL reset_disp got %h want 00", bus.display_value); end
  endtask

  task automatic test_add();
    do_reset();
    bus.operand_input = 4'h3; #1;
    checks++; if (bus.display_value !== 8'h03) begin errors++; $display("FAIL add_live_op1 got %h want 03", bus.display_value); end
    pulse();
    bus.operand_input = 4'hE; #1;
    checks++; if (bus.display_value !== 8'hFE) begin errors++; $display("FAIL add_live_op2 got %h want fe", bus.display_value); end
    pulse();
    bus.operand_input = 4'h5; #1;
    checks++; if (bus.state !== 3'd2 || bus.display_value !== 8'hFE)
      begin errors++; $display("FAIL add_oper got st=%0d disp=%h want st=2 disp=fe", bus.state, bus.display_value); end
    bus.operator_select = 2'b00; pulse();
    checks++; if (bus.state !== 3'd3 || bus.result_valid !== 1'b0)
      begin errors++; $display("FAIL add_exec got st=%0d v=%b want st=3 v=0", bus.state, bus.result_valid); end
    step();
    checks++; if (bus.state !== 3'd4 || bus.result_valid !== 1'b1 || bus.display_value !== 8'h01 || bus.ovf !== 1'b0 || bus.div_err !== 1'b0)
      begin errors++; $display("FAIL add_show got st=%0d v=%b disp=%h ovf=%b de=%b want 4 1 01 0 0",
        bus.state, bus.result_valid, bus.display_value, bus.ovf, bus.div_err); end
    step(); step();
    checks++; if (bus.state !== 3'd4 || bus.result_valid !== 1'b0 || bus.display_value !== 8'h01)
      begin errors++; $display("FAIL add_hold got st=%0d v=%b disp=%h want 4 0 01", bus.state, bus.result_valid, bus.display_value); end
  endtask

  task automatic test_mul();
    do_reset();
    run_ops(4'h7, 4'h8, 2'b10); step();
    checks++; if (bus.display_value !== 8'hC8 || bus.ovf !== 1'b1 || bus.div_err !== 1'b0 || bus.result_valid !== 1'b1)
      begin errors++; $display("FAIL mul_7x-8 got disp=%h ovf=%b de=%b v=%b want c8 1 0 1",
        bus.display_value, bus.ovf, bus.div_err, bus.result_valid); end
    do_reset();
    run_ops(4'h3, 4'hD, 2'b01); step();  // 3 - (-3) = 6, in range
    checks++; if (bus.display_value !== 8'h06 || bus.ovf !== 1'b0)
      begin errors++; $display("FAIL sub_3m-3 got disp=%h ovf=%b want 06 0", bus.display_value, bus.ovf); end
    do_reset();
    run_ops(4'h7, 4'h1, 2'b00); step();  // 7 + 1 = 8, just out of range
    checks++; if (bus.display_value !== 8'h08 || bus.ovf !== 1'b1)
      begin errors++; $display("FAIL add_7p1 got disp=%h ovf=%b want 08 1", bus.display_value, bus.ovf); end
  endtask

  task automatic test_div();
    do_reset();
    run_ops(4'h5, 4'h0, 2'b11); step();
    checks++; if (bus.display_value !== 8'h00 || bus.div_err !== 1'b1 || bus.ovf !== 1'b0)
      begin errors++; $display("FAIL div_by0 got disp=%h de=%b ovf=%b want 00 1 0", bus.display_value, bus.div_err, bus.ovf); end
    do_reset();
    run_ops(4'h8, 4'hF, 2'b11); step();
    checks++; if (bus.display_value !== 8'h08 || bus.ovf !== 1'b1 || bus.div_err !== 1'b0)
      begin errors++; $display("FAIL div_m8_m1 got disp=%h ovf=%b de=%b want 08 1 0", bus.display_value, bus.ovf, bus.div_err); end
    do_reset();
    run_ops(4'h9, 4'h2, 2'b11); step();  // -7 / 2 = -3 (toward zero)
    checks++; if (bus.display_value !== 8'hFD || bus.div_err !== 1'b0)
      begin errors++; $display("FAIL div_m7_2 got disp=%h de=%b want fd 0", bus.display_value, bus.div_err); end
  endtask

  task automatic test_reset_mid();
    int vseen;
    do_reset();
    bus.display_mode_change = 1'b1; step(); bus.display_mode_change = 1'b0;
    bus.operand_input = 4'h6; pulse();
    bus.operand_input = 4'h2; pulse();
    do_reset();
    checks++; if (bus.state !== 3'd0 || bus.display_mode !== 1'b0)
      begin errors++; $display("FAIL rst_oper got st=%0d dm=%b want 0 0", bus.state, bus.display_mode); end
    vseen = 0;
    for (int i = 0; i < 4; i++) begin step(); if (bus.result_valid) vseen++; end
    checks++; if (vseen !== 0) begin errors++; $display("FAIL rst_oper_novalid got %0d pulses want 0", vseen); end
    run_ops(4'h6, 4'h2, 2'b11);
    reset = 1'b1; step(); reset = 1'b0;   // reset lands on the S_EXEC edge
    vseen = 0;
    for (int i = 0; i < 4; i++) begin if (bus.result_valid) vseen++; step(); end
    checks++; if (vseen !== 0 || bus.state !== 3'd0)
      begin errors++; $display("FAIL rst_exec got pulses=%0d st=%0d want 0 0", vseen, bus.state); end
    run_ops(4'h6, 4'h2, 2'b01); step();
    checks++; if (bus.display_value !== 8'h04 || bus.result_valid !== 1'b1)
      begin errors++; $display("FAIL rst_after got disp=%h v=%b want 04 1", bus.display_value, bus.result_valid); end
  endtask

  task automatic test_simul();
    do_reset();
    bus.operand_input = 4'h1; pulse();
    bus.display_mode_change = 1'b1; bus.confirm = 1'b1; step();
    bus.display_mode_change = 1'b0; bus.confirm = 1'b0;
    checks++; if (bus.state !== 3'd2 || bus.display_mode !== 1'b1)
      begin errors++; $display("FAIL simul got st=%0d dm=%b want 2 1", bus.state, bus.display_mode); end
  endtask

  task automatic test_chain();
    do_reset();
    run_ops(4'h3, 4'h4, 2'b00); step();
    checks++; if (bus.display_value !== 8'h07)
      begin errors++; $display("FAIL chain_first got %h want 07", bus.display_value); end
    pulse();
`ifdef CALC_CHAIN_EN
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL chain_skip got st=%0d want 1", bus.state); end
    bus.operand_input = 4'h2; pulse();
    bus.operator_select = 2'b01; pulse(); step();
    checks++; if (bus.display_value !== 8'h05 || bus.result_valid !== 1'b1)
      begin errors++; $display("FAIL chain_sub got disp=%h v=%b want 05 1", bus.display_value, bus.result_valid); end
`else
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL chain_off got st=%0d want 0", bus.state); end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_reset_mid();
    test_simul();
    test_chain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/calc_controller.md
CALC_CONTROLLER -- requirements
Module: calc_controller

Interface
REQ-001 Parameter DATA_W, default 4: signed operand width, legal range 2..16.
REQ-002 Parameter RES_W, default 2*DATA_W: signed result width; it SHALL NOT be overridden below 2*DATA_W.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 confirm  input  1  single-cycle pulse advancing the sequence; debounced and synchronised upstream.
REQ-006 display_mode_change  input  1  single-cycle pulse toggling display_mode.
REQ-007 operator_select  input  2  op code: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-008 operand_input  input  DATA_W  signed operand from the switches.
REQ-009 state  output  3  current state encoding (calc_state_t).
REQ-010 display_value  output  RES_W  signed value for the display driver.
REQ-011 display_mode  output  1  0 decimal, 1 binary; the display driver interprets it.
REQ-012 result_valid  output  1  one-cycle pulse when a new result is registered.
REQ-013 ovf  output  1  last result falls outside the signed DATA_W range.
REQ-014 div_err  output  1  last operation was a divide by zero.

Function
REQ-015 States SHALL be S_OP1, S_OP2, S_OPER, S_EXEC and S_SHOW, with encodings 0 to 4.
REQ-016 S_OP1 on confirm: operand1 <= operand_input, go to S_OP2; S_OP2 on confirm: operand2 <= operand_input, go to S_OPER.
REQ-017 S_OPER on confirm: op <= operator_select, go to S_EXEC; S_EXEC unconditionally goes to S_SHOW after 1 cycle, ignoring confirm.
REQ-018 Latency: confirm in S_OPER at cycle n; result, ovf and div_err registered at edge n+2; state == S_SHOW and result_valid == 1 for cycle n+2 only.
REQ-019 S_SHOW on confirm goes to S_OP1; with no confirm it holds indefinitely.
REQ-020 display_value SHALL be the sign-extended live operand_input in S_OP1/S_OP2, the held operand2 in S_OPER/S_EXEC, and the registered result in S_SHOW.
REQ-021 All arithmetic SHALL be performed at RES_W after sign-extension; ADD, SUB and MUL results are exact at RES_W.
REQ-022 DIV truncates toward zero; divisor 0 gives result 0 and div_err = 1; otherwise div_err = 0.
REQ-023 ovf = 1 iff the result lies outside [-2^(DATA_W-1), 2^(DATA_W-1)-1]; both ovf and div_err are updated only at the S_EXEC edge.
REQ-024 display_mode toggles on every display_mode_change pulse in any state, including the cycle confirm is also high; both events take effect.
REQ-025 confirm held high for multiple cycles advances one state per cycle; this is the upstream's responsibility and is not filtered here.

Reset
REQ-026 reset dominates all other inputs in the same cycle: state <= S_OP1; operand1, operand2, op, result, display_mode, result_valid, ovf and div_err <= 0.
REQ-027 reset asserted mid-sequence, including in S_EXEC, discards the pending operation, and no result_valid pulse is produced.

Configuration
REQ-028 Macro CALC_CHAIN_EN: when defined, confirm in S_SHOW loads operand1 <= result[DATA_W-1:0] and goes to S_OP2, skipping S_OP1; ovf then warns of truncation.
REQ-029 Without CALC_CHAIN_EN, S_SHOW always returns to S_OP1 and operand1 is not reloaded from the result.

Structure
REQ-030 Package calc_pkg SHALL hold calc_state_t (3-bit enum), calc_op_t (2-bit enum: OP_ADD, OP_SUB, OP_MUL, OP_DIV) and the state encodings.
REQ-031 Sub-module calc_alu SHALL be combinational, parameterised by DATA_W/RES_W, and output result and div_by_zero; the FSM, operand registers and display mux live in calc_controller.

Verification
REQ-032 DATA_W=4: operands 3, -2, ADD -> display_value 1, ovf 0, result_valid exactly 2 cycles after the third confirm.
REQ-033 Operands 7, -8, MUL -> display_value -56 (8'hC8), ovf 1, div_err 0.
REQ-034 Operands 5, 0, DIV -> display_value 0, div_err 1; then operands -8, -1, DIV -> 8, ovf 1, div_err 0.
REQ-035 reset pulse in S_OPER after operands 6, 2 -> state S_OP1, display_mode 0, no result_valid pulse; the next full sequence computes correctly.
REQ-036 confirm and display_mode_change pulsed in the same cycle in S_OP2 -> state S_OPER and display_mode toggled.
REQ-037 With CALC_CHAIN_EN: 3+4=7, then confirm, operand 2, SUB -> 5; without the macro, the same confirm returns to S_OP1.
